// File: rtl/glb_bank_arbiter.sv
// Shares one single-port SRAM bank between processor (0), stream (1) and parallel-config (2)
// requesters. Optional build macro GLB_BANK_ARB_PROC_PRIO_EN gives the processor strict priority.
module glb_bank_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clk_en,
  input  logic [2:0]                                    req_valid,
  output logic [2:0]                                    req_ready,
  input  logic [2:0]                                    req_wr,
  input  logic [3*ADDR_WIDTH-1:0]                       req_addr,
  input  logic [3*DATA_WIDTH-1:0]                       req_data,
  input  logic [3*(DATA_WIDTH/8)-1:0]                   req_strb,
  output logic [2:0]                                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                         rsp_data,
  output logic                                          mem_cen,
  output logic                                          mem_wen,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]                         mem_data_in,
  output logic [DATA_WIDTH-1:0]                         mem_bit_sel,
  input  logic [DATA_WIDTH-1:0]                         mem_data_out,
  output logic [2:0]                                    rd_outstanding
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int MAW    = ADDR_WIDTH - OFF;

  function automatic logic [DATA_WIDTH-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    for (int b = 0; b < STRB_W; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] start);
    logic [2:0] g;
    g = 3'b000;
    case (start)
      2'd0: if (v[0]) g = 3'b001; else if (v[1]) g = 3'b010; else if (v[2]) g = 3'b100; else g = 3'b000;
      2'd1: if (v[1]) g = 3'b010; else if (v[2]) g = 3'b100; else if (v[0]) g = 3'b001; else g = 3'b000;
      2'd2: if (v[2]) g = 3'b100; else if (v[0]) g = 3'b001; else if (v[1]) g = 3'b010; else g = 3'b000;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  logic [2:0]            gnt_s;
  logic                  sel_wr_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [STRB_W-1:0]     sel_strb_s;
  logic                  rd_accept_s, rsp_any_s;

  logic                  mem_cen_q, mem_cen_d, mem_wen_q, mem_wen_d;
  logic [MAW-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d, mem_bit_sel_q, mem_bit_sel_d;
  logic [2:0]            issue_tag_q, issue_tag_d;
  logic [2:0]            tag_pipe_q [RD_LATENCY];
  logic [2:0]            tag_pipe_d [RD_LATENCY];
  logic [2:0]            rd_outstanding_q, rd_outstanding_d;

`ifdef GLB_BANK_ARB_PROC_PRIO_EN
  // rr_ptr_q = 0 prefers stream (1), 1 prefers parallel-config (2)
  logic rr_ptr_q, rr_ptr_d;

  // Grant selection: processor first, then 1/2 alternate
  always_comb begin
    gnt_s    = 3'b000;
    rr_ptr_d = rr_ptr_q;
    if (clk_en && !reset) begin
      if (req_valid[0]) gnt_s = 3'b001;
      else if (!rr_ptr_q) gnt_s = req_valid[1] ? 3'b010 : (req_valid[2] ? 3'b100 : 3'b000);
      else gnt_s = req_valid[2] ? 3'b100 : (req_valid[1] ? 3'b010 : 3'b000);
      if (gnt_s[1]) rr_ptr_d = 1'b1;
      else if (gnt_s[2]) rr_ptr_d = 1'b0;
      else rr_ptr_d = rr_ptr_q;
    end else begin
      gnt_s    = 3'b000;
      rr_ptr_d = rr_ptr_q;
    end
  end
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // Grant selection: scan upward from rr_ptr, pointer moves past the winner
  always_comb begin
    gnt_s    = 3'b000;
    rr_ptr_d = rr_ptr_q;
    if (clk_en && !reset) begin
      gnt_s = rr_pick(req_valid, rr_ptr_q);
      case (gnt_s)
        3'b001:  rr_ptr_d = 2'd1;
        3'b010:  rr_ptr_d = 2'd2;
        3'b100:  rr_ptr_d = 2'd0;
        default: rr_ptr_d = rr_ptr_q;
      endcase
    end else begin
      gnt_s    = 3'b000;
      rr_ptr_d = rr_ptr_q;
    end
  end
`endif

  // One-hot AND-OR mux of the winning request
  always_comb begin
    sel_wr_s   = 1'b0;
    sel_addr_s = {ADDR_WIDTH{1'b0}};
    sel_data_s = {DATA_WIDTH{1'b0}};
    sel_strb_s = {STRB_W{1'b0}};
    for (int i = 0; i < 3; i++) begin
      sel_wr_s   = sel_wr_s | (gnt_s[i] & req_wr[i]);
      sel_addr_s = sel_addr_s | ({ADDR_WIDTH{gnt_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_data_s = sel_data_s | ({DATA_WIDTH{gnt_s[i]}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
      sel_strb_s = sel_strb_s | ({STRB_W{gnt_s[i]}} & req_strb[i*STRB_W +: STRB_W]);
    end
  end

  // Issue register next state; bank fields hold on idle cycles
  always_comb begin
    mem_cen_d     = 1'b0;
    mem_wen_d     = mem_wen_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_bit_sel_d = mem_bit_sel_q;
    issue_tag_d   = 3'b000;
    if (|gnt_s) begin
      mem_cen_d     = 1'b1;
      mem_wen_d     = sel_wr_s;
      mem_addr_d    = MAW'(sel_addr_s >> OFF);
      mem_data_in_d = sel_data_s;
      mem_bit_sel_d = sel_wr_s ? strb_to_mask(sel_strb_s) : {DATA_WIDTH{1'b1}};
      issue_tag_d   = sel_wr_s ? 3'b000 : gnt_s;
    end else begin
      mem_cen_d   = 1'b0;
      issue_tag_d = 3'b000;
    end
  end

  // Read tags enter when the read is on the bank pins and emerge with its data
  always_comb begin
    tag_pipe_d[0] = issue_tag_q;
    for (int k = 1; k < RD_LATENCY; k++) tag_pipe_d[k] = tag_pipe_q[k-1];
  end

  assign rd_accept_s = |(gnt_s & ~req_wr);
  assign rsp_any_s   = |tag_pipe_q[RD_LATENCY-1];

  // Outstanding-read counter
  always_comb begin
    rd_outstanding_d = rd_outstanding_q;
    case ({rd_accept_s, rsp_any_s})
      2'b10:   rd_outstanding_d = rd_outstanding_q + 3'd1;
      2'b01:   rd_outstanding_d = rd_outstanding_q - 3'd1;
      default: rd_outstanding_d = rd_outstanding_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q         <= '0;
      mem_cen_q        <= 1'b0;
      mem_wen_q        <= 1'b0;
      mem_addr_q       <= {MAW{1'b0}};
      mem_data_in_q    <= {DATA_WIDTH{1'b0}};
      mem_bit_sel_q    <= {DATA_WIDTH{1'b0}};
      issue_tag_q      <= 3'b000;
      rd_outstanding_q <= 3'd0;
      for (int k = 0; k < RD_LATENCY; k++) tag_pipe_q[k] <= 3'b000;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      mem_cen_q        <= mem_cen_d;
      mem_wen_q        <= mem_wen_d;
      mem_addr_q       <= mem_addr_d;
      mem_data_in_q    <= mem_data_in_d;
      mem_bit_sel_q    <= mem_bit_sel_d;
      issue_tag_q      <= issue_tag_d;
      rd_outstanding_q <= rd_outstanding_d;
      tag_pipe_q       <= tag_pipe_d;
    end
  end

  assign req_ready      = gnt_s;
  assign rsp_valid      = tag_pipe_q[RD_LATENCY-1];
  assign rsp_data       = mem_data_out;
  assign mem_cen        = mem_cen_q;
  assign mem_wen        = mem_wen_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data_in    = mem_data_in_q;
  assign mem_bit_sel    = mem_bit_sel_q;
  assign rd_outstanding = rd_outstanding_q;

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// Self-checking bench for glb_bank_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference with its own bank memory.
module tb_glb_bank_arbiter;
  localparam int AW     = 19;
  localparam int DW     = 64;
  localparam int SW     = DW / 8;
  localparam int MAW    = 16;
  localparam int RD_LAT = 2;
  localparam int NCYC   = 4096;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clk_en;
  logic [2:0]      req_valid, req_ready, req_wr, rsp_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [3*SW-1:0] req_strb;
  logic [DW-1:0]   rsp_data, mem_data_in, mem_bit_sel, mem_data_out;
  logic            mem_cen, mem_wen;
  logic [MAW-1:0]  mem_addr;
  logic [2:0]      rd_outstanding;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  glb_bank_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_bit_sel(mem_bit_sel), .mem_data_out(mem_data_out),
    .rd_outstanding(rd_outstanding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank macro model: unwritten words return an address-derived pattern
  logic [DW-1:0] bank [0:65535];
  bit            bank_wr [0:65535];
  logic [DW-1:0] rd_pipe [RD_LAT];

  function automatic logic [DW-1:0] pat(input logic [MAW-1:0] a);
    return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
  endfunction

  function automatic logic [DW-1:0] bank_rd(input logic [MAW-1:0] a);
    return bank_wr[a] ? bank[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    if (mem_cen && mem_wen) begin
      bank[mem_addr]    <= (bank_rd(mem_addr) & ~mem_bit_sel) | (mem_data_in & mem_bit_sel);
      bank_wr[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= (mem_cen && !mem_wen) ? bank_rd(mem_addr) : {DW{1'b0}};
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_data_out = rd_pipe[RD_LAT-1];

  // Reference model state
  int            m_ptr;
  logic [DW-1:0] ref_mem [0:65535];
  bit            ref_wr [0:65535];
  int            exp_id [NCYC];
  logic [DW-1:0] exp_dat [NCYC];
  int            rd_acc_q [$];
  logic          e_cen, e_wen;
  logic [MAW-1:0] e_addr;
  logic [DW-1:0] e_din, e_bs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int c = 0; c < NCYC; c++) exp_id[c] = -1;
    rd_acc_q.delete();
    e_cen = 1'b0; e_wen = 1'b0; e_addr = '0; e_din = '0; e_bs = '0;
  endtask

  function automatic logic [2:0] model_grant(input logic [2:0] v, input logic en);
    logic [2:0] g;
    int idx;
    g = 3'b000;
    if (en) begin
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
      if (v[0]) g = 3'b001;
      for (int k = 0; k < 2; k++) begin
        idx = 1 + ((m_ptr + k) % 2);
        if (g == 3'b000 && v[idx]) g = 3'(1 << idx);
      end
`else
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (g == 3'b000 && v[idx]) g = 3'(1 << idx);
      end
`endif
    end
    return g;
  endfunction

  task automatic model_accept();
    logic [2:0]    g;
    int            idx;
    logic [AW-1:0] a;
    logic [MAW-1:0] w;
    logic [DW-1:0] d, bs, old;
    logic [SW-1:0] s;
    g = model_grant(req_valid, clk_en);
    chk("req_ready", 64'(req_ready), 64'(g));
    idx = -1;
    for (int i = 0; i < 3; i++) if (g[i]) idx = i;
    if (idx < 0) begin
      e_cen = 1'b0;
    end else begin
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
      if (idx != 0) m_ptr = idx % 2;
`else
      m_ptr = (idx + 1) % 3;
`endif
      a = req_addr[idx*AW +: AW];
      w = MAW'(a / SW);
      d = req_data[idx*DW +: DW];
      s = req_strb[idx*SW +: SW];
      bs = {DW{1'b1}};
      if (req_wr[idx]) begin
        bs = '0;
        for (int b = 0; b < SW; b++) if (s[b]) bs = bs | (64'hFF << (8 * b));
      end
      e_cen = 1'b1; e_wen = req_wr[idx]; e_addr = w; e_din = d; e_bs = bs;
      old = ref_wr[w] ? ref_mem[w] : pat(w);
      if (req_wr[idx]) begin
        ref_mem[w] = (old & ~bs) | (d & bs);
        ref_wr[w]  = 1'b1;
      end else begin
        if (cyc + 1 + RD_LAT < NCYC) begin
          exp_id[cyc + 1 + RD_LAT]  = idx;
          exp_dat[cyc + 1 + RD_LAT] = old;
        end
        rd_acc_q.push_back(cyc);
      end
    end
  endtask

  task automatic check_regs();
    logic [2:0] ev;
    chk("mem_cen", 64'(mem_cen), 64'(e_cen));
    chk("mem_wen", 64'(mem_wen), 64'(e_wen));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_data_in", mem_data_in, e_din);
    chk("mem_bit_sel", mem_bit_sel, e_bs);
    ev = (exp_id[cyc] < 0) ? 3'b000 : 3'(1 << exp_id[cyc]);
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (exp_id[cyc] >= 0) chk("rsp_data", rsp_data, exp_dat[cyc]);
    while (rd_acc_q.size() > 0 && rd_acc_q[0] + 1 + RD_LAT < cyc) void'(rd_acc_q.pop_front());
    chk("rd_outstanding", 64'(rd_outstanding), 64'(rd_acc_q.size()));
  endtask

  // One clock: model sees the applied inputs, then registered outputs are compared
  task automatic step();
    #1;
    model_accept();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_strb[i*SW +: SW] = s;
  endtask

  task automatic idle(input int n);
    req_valid = 3'b000;
    repeat (n) step();
  endtask

  typedef struct {
    logic [2:0] valid;
    logic       en;
    logic [2:0] exp_ready;
  } vec_t;
  vec_t tbl [15];

  initial begin
    bit found;
`ifdef GLB_BANK_ARB_PROC_PRIO_EN
    tbl = '{'{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b001},
            '{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b001},
            '{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b001},
            '{3'b110,1'b1,3'b010}, '{3'b011,1'b1,3'b001}, '{3'b000,1'b1,3'b000},
            '{3'b101,1'b0,3'b000}, '{3'b101,1'b1,3'b001}, '{3'b100,1'b1,3'b100}};
`else
    tbl = '{'{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b010}, '{3'b111,1'b1,3'b100},
            '{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b010}, '{3'b111,1'b1,3'b100},
            '{3'b111,1'b1,3'b001}, '{3'b111,1'b1,3'b010}, '{3'b111,1'b1,3'b100},
            '{3'b110,1'b1,3'b010}, '{3'b011,1'b1,3'b001}, '{3'b000,1'b1,3'b000},
            '{3'b101,1'b0,3'b000}, '{3'b101,1'b1,3'b100}, '{3'b100,1'b1,3'b100}};
`endif
    reset = 1'b1;
    clk_en = 1'b1; req_valid = 3'b111; req_wr = 3'b000;
    req_addr = '0; req_data = '0; req_strb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_mem_cen", 64'(mem_cen), 64'h0);
    chk("rst_mem_wen", 64'(mem_wen), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_data_in", mem_data_in, 64'h0);
    chk("rst_mem_bit_sel", mem_bit_sel, 64'h0);
    chk("rst_rd_outstanding", 64'(rd_outstanding), 64'h0);
    reset = 1'b0;

    // Vector table from reset: fairness order, partial valids, clk_en gating
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, 19'(i * 256 + r * 8), 64'h0, 8'hFF);
      req_valid = tbl[r].valid;
      clk_en = tbl[r].en;
      #1;
      chk("tbl_ready", 64'(req_ready), 64'(tbl[r].exp_ready));
      step();
    end
    clk_en = 1'b1;
    idle(6);

    // Single read by stream requester
    set_req(1, 1'b0, 19'h40, 64'h0, 8'h00);
    req_valid = 3'b010;
    step();
    chk("rd_cen", 64'(mem_cen), 64'h1);
    chk("rd_wen", 64'(mem_wen), 64'h0);
    chk("rd_addr", 64'(mem_addr), 64'h8);
    req_valid = 3'b000;
    repeat (RD_LAT) step();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'h2);
    step();
    chk("rd_outstanding_done", 64'(rd_outstanding), 64'h0);

    // Masked write by processor
    set_req(0, 1'b1, 19'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    req_valid = 3'b001;
    step();
    chk("wr_wen", 64'(mem_wen), 64'h1);
    chk("wr_addr", 64'(mem_addr), 64'h1);
    chk("wr_bit_sel", mem_bit_sel, 64'h0000_0000_FFFF_FFFF);
    idle(RD_LAT + 2);

    // Write then read of the same address
    set_req(2, 1'b1, 19'h100, 64'hA5, 8'hFF);
    req_valid = 3'b100;
    step();
    set_req(2, 1'b0, 19'h100, 64'h0, 8'h00);
    step();
    req_valid = 3'b000;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      if (rsp_valid == 3'b100) found = 1'b1;
      else step();
    end
    chk("hazard_seen", 64'(found), 64'h1);
    chk("hazard_data", rsp_data, 64'hA5);
    idle(RD_LAT + 2);

    // clk_en drop right after a read accept
    set_req(1, 1'b0, 19'h40, 64'h0, 8'h00);
    req_valid = 3'b010;
    step();
    clk_en = 1'b0;
    req_valid = 3'b111;
    for (int j = 1; j <= 5; j++) begin
      #1;
      chk("gated_ready", 64'(req_ready), 64'h0);
      step();
      if (j == RD_LAT) chk("gated_rsp", 64'(rsp_valid), 64'h2);
    end
    clk_en = 1'b1;
    idle(RD_LAT + 2);

    // Reset one cycle after a read accept
    set_req(1, 1'b0, 19'h48, 64'h0, 8'h00);
    req_valid = 3'b010;
    step();
    req_valid = 3'b111;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    chk("mid_rst_cen", 64'(mem_cen), 64'h0);
    chk("mid_rst_addr", 64'(mem_addr), 64'h0);
    chk("mid_rst_bit_sel", mem_bit_sel, 64'h0);
    chk("mid_rst_rsp", 64'(rsp_valid), 64'h0);
    chk("mid_rst_outstanding", 64'(rd_outstanding), 64'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(RD_LAT + 4);

    // Randomized traffic against the reference model
    for (int t = 0; t < 1200; t++) begin
      for (int i = 0; i < 3; i++)
        set_req(i, 1'($urandom_range(0, 1)), 19'(($urandom_range(0, 31) << 3) | $urandom_range(0, 7)),
                {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      req_valid = 3'($urandom_range(0, 7));
      clk_en = ($urandom_range(0, 7) != 0);
      step();
    end
    clk_en = 1'b1;
    idle(RD_LAT + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/glb_bank_arbiter.md
# glb_bank_arbiter

Single-port SRAM bank arbiter for a global buffer tile. It shares one bank port between three requesters: processor (0), stream (1) and parallel-config (2). Grants use round-robin with registered issue to the bank. Read data is returned to the originating requester through a fixed-latency tag pipeline. It sits between the tile's core router/DMA logic and one SRAM bank macro.

## Interface
Parameters:
- ADDR_WIDTH, 19, bank byte-address width
- DATA_WIDTH, 64, bank word width (multiple of 8)
- RD_LATENCY, 2, cycles from mem_cen (read) to valid mem_data_out; legal 1..4

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  when low, no new grants; issue and tag pipelines keep advancing
- req_valid  in  3  per-requester request valid (bit i = requester i)
- req_ready  out  3  per-requester accept; one-hot or zero
- req_wr  in  3  1 = write, 0 = read
- req_addr  in  3×ADDR_WIDTH  byte address, requester i at slice i
- req_data  in  3×DATA_WIDTH  write data
- req_strb  in  3×(DATA_WIDTH/8)  write byte enables
- rsp_valid  out  3  read-data valid for requester i; one-hot or zero
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters
- mem_cen  out  1  bank chip enable, active-high
- mem_wen  out  1  bank write enable, active-high
- mem_addr  out  ADDR_WIDTH-log2(DATA_WIDTH/8)  word address
- mem_data_in  out  DATA_WIDTH  write data
- mem_bit_sel  out  DATA_WIDTH  bit-level write mask
- mem_data_out  in  DATA_WIDTH  bank read data
- rd_outstanding  out  3  number of reads issued but not yet returned

## Operation
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. req_ready is combinational from req_valid, the pointer and clk_en. It never asserts for a requester whose valid is low.
- Arbitration: one grant per cycle, only when clk_en=1. Candidates are scanned from rr_ptr upward, mod 3. The first valid requester wins.
- Pointer update: after a grant to i, rr_ptr ← (i+1) mod 3. With no grant, rr_ptr holds. Reset value is 0.
- Issue register: the accepted request is registered. The cycle after acceptance drives:
  - mem_cen=1
  - mem_wen=req_wr
  - mem_addr = req_addr >> log2(DATA_WIDTH/8)
  - mem_data_in = req_data
  - mem_bit_sel with byte b replicated to bits [8b+7:8b] from strb bit b; all ones for reads
- Idle cycles: mem_cen=0. The other mem outputs hold their last value.
- Tag pipeline: a read issue pushes one-hot tag(i) into a RD_LATENCY-deep shift register; writes and idle cycles push zero. When the tag emerges, rsp_valid = tag and rsp_data = mem_data_out, taken combinationally the same cycle.
- No back-pressure on responses: a requester must always accept rsp_valid.
- rd_outstanding: +1 on a read accept, −1 on a rsp_valid cycle, net 0 if both happen in the same cycle. Maximum value is RD_LATENCY+1.
- Same-address write then read, back to back: the read observes the new data, because bank order equals grant order.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, mem_cen=0, mem_wen=0
  - mem_addr, mem_data_in, mem_bit_sel = 0
  - rd_outstanding=0, rr_ptr=0, tag pipeline all zero
- Latency:
  - accept at cycle N → mem_cen at N+1
  - read data: rsp_valid at N+1+RD_LATENCY
- Throughput: one request per cycle sustained. With all three valid, each requester is granted once every 3 cycles.
- Simultaneous events: at most one grant per cycle. rsp_valid for an earlier read may coincide with a new grant; they are independent.
- clk_en drop: requests already in the issue register and tag pipeline complete normally. req_ready=0 while clk_en=0.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid is produced for them. Requesters must drop their own outstanding state on reset.

## Configuration
- GLB_BANK_ARB_PROC_PRIO_EN
- Defined: requester 0 (processor) has strict priority and is granted whenever valid. Requesters 1 and 2 round-robin between themselves on the remaining cycles, using a 1-bit pointer. rr_ptr updates only on grants to 1 or 2.
- Undefined: plain 3-way round-robin as described in Operation.

## Test plan
- Single read: requester 1 reads addr 0x40, RD_LATENCY=2, accept at cycle 10 → mem_cen=1, mem_wen=0, mem_addr=0x8 at cycle 11; rsp_valid=3'b010 and rsp_data=mem_data_out at cycle 13; rd_outstanding returns to 0.
- Masked write: requester 0 writes addr 0x8, data 0xFFFF_FFFF_FFFF_FFFF, strb 0x0F → mem_wen=1, mem_addr=0x1, mem_bit_sel=0x0000_0000_FFFF_FFFF one cycle after accept; no rsp_valid.
- Fairness: all three req_valid held high for 9 cycles from reset → grant order 0,1,2,0,1,2,0,1,2; with the macro defined, order is 0 on every cycle.
- clk_en gating: clk_en=0 for 5 cycles with req_valid=3'b111 → req_ready=0 throughout; a read accepted one cycle before the drop still returns rsp_valid on schedule.
- Write-then-read hazard: requester 2 writes 0xA5 to 0x100, then requester 2 reads 0x100 on the next cycle → rsp_data=0xA5 (bank model).
- Reset mid-flight: reset asserted one cycle after a read accept → all outputs return to reset values immediately; no rsp_valid appears afterward; rd_outstanding=0.
